// File: rtl/input_dev_pkg.sv
// Shared encodings for the input device controller: FSM states, bus
// register addresses and status bit positions.
package input_dev_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_RAW    = 2'd2;
  localparam logic [1:0] ADDR_COUNT  = 2'd3;

  localparam int ST_NEW = 0;
  localparam int ST_OVR = 1;

endpackage

// File: rtl/input_sync2.sv
// Two-flop synchroniser for a bus of independent asynchronous inputs.
// Bits are synchronised individually; no cross-bit coherency is implied.
module input_sync2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/input_dev_ctrl.sv
// Debounces synchronised device inputs, commits stable values and serves
// four read-only bus registers. Optional Irq output with INPUT_DEV_IRQ_EN.
//
// state  | meaning
// IDLE   | sync_q matches committed value, waiting for a change
// SETTLE | candidate seen, counting stable cycles
// COMMIT | one cycle: publish candidate, set NewFlag, bump change count
module input_dev_ctrl
  import input_dev_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] DevIn,
  input  logic             RdEn,
  input  logic [1:0]       Addr,
  output logic [31:0]      DataOut,
  output logic             DataValid
`ifdef INPUT_DEV_IRQ_EN
  ,
  output logic             Irq
`endif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             new_q, new_d;
  logic             ovr_q, ovr_d;
  logic [15:0]      chg_q, chg_d;
  logic             rd_data;
  logic [31:0]      rd_mux;

  input_sync2 #(.WIDTH(WIDTH)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (DevIn),
    .q   (sync_q)
  );

  assign rd_data = RdEn && (Addr == ADDR_DATA);

  // Debounce timer counts down from DEBOUNCE_CYCLES-1; terminal count is zero.
  always_comb begin
    state_d  = state_q;
    stable_d = stable_q;
    cand_d   = cand_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    new_d    = new_q;
    ovr_d    = ovr_q;
    chg_d    = chg_q;
    case (state_q)
      IDLE: begin
        if (sync_q != stable_q) begin
          cand_d  = sync_q;
          cnt_d   = CNT_LOAD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (sync_q != cand_q) begin
          cand_d = sync_q;
          cnt_d  = CNT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = COMMIT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      COMMIT: begin
        stable_d = cand_q;
        data_d   = cand_q;
        new_d    = 1'b1;
        if (new_q) ovr_d = 1'b1;
        chg_d    = chg_q + 16'd1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A data read racing a commit leaves the fresh data flagged as new.
    if (rd_data) begin
      ovr_d = 1'b0;
      if (state_q != COMMIT) new_d = 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (Addr)
      ADDR_DATA: rd_mux = 32'(data_q);
      ADDR_STATUS: begin
        rd_mux[ST_NEW] = new_q;
        rd_mux[ST_OVR] = ovr_q;
      end
      ADDR_RAW:   rd_mux = 32'(sync_q);
      ADDR_COUNT: rd_mux = {16'b0, chg_q};
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      stable_q  <= '0;
      cand_q    <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      new_q     <= 1'b0;
      ovr_q     <= 1'b0;
      chg_q     <= '0;
      DataOut   <= '0;
      DataValid <= 1'b0;
    end else begin
      state_q   <= state_d;
      stable_q  <= stable_d;
      cand_q    <= cand_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      new_q     <= new_d;
      ovr_q     <= ovr_d;
      chg_q     <= chg_d;
      DataValid <= RdEn;
      if (RdEn) DataOut <= rd_mux;
    end
  end

`ifdef INPUT_DEV_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) Irq <= 1'b0;
    else     Irq <= new_q;
  end
`endif

endmodule

// File: tb/tb_input_dev_ctrl.sv
// Directed bench for input_dev_ctrl with DEBOUNCE_CYCLES=4: a vector table
// of debounce scenarios plus hand sequences for latency, read/commit race and reset.
module tb_input_dev_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] DevIn = '0;
  logic        RdEn = 1'b0;
  logic [1:0]  Addr = '0;
  logic [31:0] DataOut;
  logic        DataValid;
`ifdef INPUT_DEV_IRQ_EN
  logic        Irq;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  input_dev_ctrl #(.WIDTH(32), .DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .DevIn     (DevIn),
    .RdEn      (RdEn),
    .Addr      (Addr),
    .DataOut   (DataOut),
    .DataValid (DataValid)
`ifdef INPUT_DEV_IRQ_EN
    ,
    .Irq       (Irq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pulse;
    int          pulse_len;
    logic [31:0] base;
    int          wait_cyc;
    logic [31:0] exp_st;
    logic [31:0] exp_cnt;
    bit          do_rd;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    RdEn = 1'b1;
    Addr = a;
    tick(1);
    RdEn = 1'b0;
    chk({name, "_valid"}, {31'b0, DataValid}, 32'd1);
    chk(name, DataOut, exp);
  endtask

  initial begin
    // glitch from A5 re-settles on A5: same value committed again
    vecs[0] = '{32'h1,        3,  32'hA5,       15, 32'd1, 32'd2, 1'b1, 32'hA5};
    vecs[1] = '{32'h1,        20, 32'h1,        0,  32'd1, 32'd3, 1'b0, 32'h0};
    vecs[2] = '{32'h2,        20, 32'h2,        0,  32'd3, 32'd4, 1'b1, 32'h2};
    vecs[3] = '{32'h2,        20, 32'h2,        0,  32'd0, 32'd4, 1'b1, 32'h2};
    vecs[4] = '{32'h0,        2,  32'h2,        15, 32'd1, 32'd5, 1'b1, 32'h2};
    vecs[5] = '{32'hFFFFFFFF, 20, 32'hFFFFFFFF, 0,  32'd1, 32'd6, 1'b1, 32'hFFFFFFFF};

    // 1: reset, idle inputs
    tick(3);
    chk("rst_dataout", DataOut, 32'h0);
    chk("rst_valid", {31'b0, DataValid}, 32'h0);
    rst = 1'b0;
    tick(20);
    rd(2'd1, 32'h0, "t1_status");
    tick(1);
    chk("t1_valid_pulse", {31'b0, DataValid}, 32'h0);
    rd(2'd3, 32'h0, "t1_count");
    rd(2'd0, 32'h0, "t1_data");

    // 2: exact commit latency, then register contents
    DevIn = 32'hA5;
    tick(6);
    rd(2'd3, 32'h0, "t2_count_e7");
    rd(2'd3, 32'h0, "t2_count_e8");
    rd(2'd3, 32'h1, "t2_count_e9");
`ifdef INPUT_DEV_IRQ_EN
    chk("t2_irq", {31'b0, Irq}, 32'h1);
`endif
    rd(2'd1, 32'h1, "t2_status_new");
    rd(2'd0, 32'hA5, "t2_data");
    rd(2'd1, 32'h0, "t2_status_clr");
    rd(2'd2, 32'hA5, "t2_raw");

    // 3/4: debounce scenario table
    for (int i = 0; i < 6; i++) begin
      DevIn = vecs[i].pulse;
      tick(vecs[i].pulse_len);
      DevIn = vecs[i].base;
      tick(vecs[i].wait_cyc);
      rd(2'd1, vecs[i].exp_st, $sformatf("vec%0d_status", i));
      rd(2'd3, vecs[i].exp_cnt, $sformatf("vec%0d_count", i));
      if (vecs[i].do_rd) rd(2'd0, vecs[i].exp_data, $sformatf("vec%0d_data", i));
    end

    // 5: data read in the COMMIT cycle, with NewFlag already pending
    DevIn = 32'h3;
    tick(20);
    DevIn = 32'h4;
    tick(7);
    rd(2'd0, 32'h3, "t5_race_old");
    rd(2'd1, 32'h1, "t5_status");
    rd(2'd0, 32'h4, "t5_data");
    rd(2'd3, 32'h8, "t5_count");

    // 6: reset while settling drops a pending read
    DevIn = 32'h5;
    tick(4);
    rst  = 1'b1;
    RdEn = 1'b1;
    Addr = 2'd3;
    tick(1);
    chk("t6_dataout", DataOut, 32'h0);
    chk("t6_valid", {31'b0, DataValid}, 32'h0);
`ifdef INPUT_DEV_IRQ_EN
    chk("t6_irq", {31'b0, Irq}, 32'h0);
`endif
    rst   = 1'b0;
    RdEn  = 1'b0;
    DevIn = 32'h0;
    tick(20);
    rd(2'd3, 32'h0, "t6_count");
    rd(2'd1, 32'h0, "t6_status");
    rd(2'd0, 32'h0, "t6_data");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
